uart_tx: RTL and testbench

- UART serial transmitter, driven by the shared 16x oversampling baud tick (s_tick).
- Accepts one parallel byte on a start strobe and emits a serial frame: start bit, DBIT data bits LSB-first, optional parity bit, then stop bit(s).
- Sits on the peripheral side of the APB UART, opposite the receive path, and shares its baud generator and frame parameters.

---
 rtl/uart_tx_if.sv | 22 ++
 rtl/uart_tx.sv | 144 ++++++++++++++
 tb/tb_uart_tx.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// UART transmitter handshake bundle: start strobe, oversample tick and byte in,
// serial line plus busy/done status out.
interface uart_tx_if;
  logic       tx_start;
  logic       s_tick;
  logic [7:0] din;
  logic       tx;
  logic       tx_busy;
  logic       tx_done_tick;

  // Requester side (bus bridge or bench)
  modport master (
    output tx_start, s_tick, din,
    input  tx, tx_busy, tx_done_tick
  );

  // Transmitter side
  modport slave (
    input  tx_start, s_tick, din,
    output tx, tx_busy, tx_done_tick
  );
endinterface

// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, DBIT data bits LSB-first, optional
// parity bit, SB_TICK/16 stop bits, paced by a 16x oversampling s_tick.
module uart_tx #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned PARITY  = 0
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam int unsigned TICK_W = 5;
  localparam int unsigned BIT_W  = 3;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(15);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DBIT - 1);
  localparam bit HAS_PAR = (PARITY != 0);
  localparam bit ODD_PAR = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            r_state;
  logic [TICK_W-1:0] r_tick;
  logic [BIT_W-1:0]  r_bit;
  logic [7:0]        r_shift;
  logic              r_par;
  logic              r_tx;
  logic              r_busy;
  logic              w_par_nxt;
  logic              w_done;

  // Parity accumulator including the data bit currently on the line
  assign w_par_nxt = r_par ^ r_shift[0];

  // Done pulse is the final stop tick itself, so it leads the return to idle
  assign w_done = (r_state == S_STOP) && bus.s_tick && (r_tick == STOP_LAST);

  assign bus.tx           = r_tx;
  assign bus.tx_busy      = r_busy;
  assign bus.tx_done_tick = w_done;

  // Frame sequencer; tx is loaded with the level of the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A tick coinciding with the start strobe is not counted
          if (bus.tx_start) begin
            r_state <= S_START;
            r_shift <= bus.din;
            r_tick  <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (bus.s_tick) begin
            if (r_tick == TICK_LAST) begin
              r_state <= S_DATA;
              r_tick  <= '0;
              r_bit   <= '0;
              r_tx    <= r_shift[0];
            end else begin
              r_tick <= r_tick + TICK_W'(1);
            end
          end
        end

        S_DATA: begin
          if (bus.s_tick) begin
            if (r_tick == TICK_LAST) begin
              r_tick  <= '0;
              r_par   <= w_par_nxt;
              r_shift <= {1'b0, r_shift[7:1]};
              if (r_bit == BIT_LAST) begin
                if (HAS_PAR) begin
                  r_state <= S_PARITY;
                  r_tx    <= ODD_PAR ? ~w_par_nxt : w_par_nxt;
                end else begin
                  r_state <= S_STOP;
                  r_tx    <= 1'b1;
                end
              end else begin
                r_bit <= r_bit + BIT_W'(1);
                r_tx  <= r_shift[1];
              end
            end else begin
              r_tick <= r_tick + TICK_W'(1);
            end
          end
        end

        S_PARITY: begin
          if (bus.s_tick) begin
            if (r_tick == TICK_LAST) begin
              r_state <= S_STOP;
              r_tick  <= '0;
              r_tx    <= 1'b1;
            end else begin
              r_tick <= r_tick + TICK_W'(1);
            end
          end
        end

        S_STOP: begin
          if (bus.s_tick) begin
            if (r_tick == STOP_LAST) begin
              r_state <= S_IDLE;
              r_tick  <= '0;
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_tick <= r_tick + TICK_W'(1);
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations (8N1, 8E1, 8O1, 8N2) share one
// stimulus stream; a per-tick frame model predicts every output each cycle.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic       s_tick;
  logic [7:0] din;

  int errs;
  int checks;
  int per;     // s_tick period in clks; 0 = random ticks
  int tph;

  always #5 clk = ~clk;

  uart_tx_if if_n ();
  uart_tx_if if_e ();
  uart_tx_if if_o ();
  uart_tx_if if_s ();

  assign if_n.tx_start = tx_start;
  assign if_n.s_tick   = s_tick;
  assign if_n.din      = din;
  assign if_e.tx_start = tx_start;
  assign if_e.s_tick   = s_tick;
  assign if_e.din      = din;
  assign if_o.tx_start = tx_start;
  assign if_o.s_tick   = s_tick;
  assign if_o.din      = din;
  assign if_s.tx_start = tx_start;
  assign if_s.s_tick   = s_tick;
  assign if_s.din      = din;

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u_n (.clk(clk), .rst(rst), .bus(if_n));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u_e (.clk(clk), .rst(rst), .bus(if_e));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u_o (.clk(clk), .rst(rst), .bus(if_o));
  uart_tx #(.DBIT(8), .SB_TICK(32), .PARITY(0)) u_s (.clk(clk), .rst(rst), .bus(if_s));

  logic [3:0] o_tx, o_busy, o_done;
  assign o_tx   = {if_s.tx, if_o.tx, if_e.tx, if_n.tx};
  assign o_busy = {if_s.tx_busy, if_o.tx_busy, if_e.tx_busy, if_n.tx_busy};
  assign o_done = {if_s.tx_done_tick, if_o.tx_done_tick, if_e.tx_done_tick, if_n.tx_done_tick};

  int c_par[4] = '{0, 2, 1, 0};
  int c_sb[4]  = '{16, 16, 16, 32};

  // Reference model: a frame is a list of line levels, one per s_tick
  logic m_act[4];
  int   m_n[4];
  int   m_tot[4];
  logic m_lv[4][256];

  function automatic void build(input int k, input logic [7:0] b);
    int p;
    int ones;
    logic pb;
    p = 0;
    ones = 0;
    for (int t = 0; t < 16; t++) begin m_lv[k][p] = 1'b0; p++; end
    for (int i = 0; i < 8; i++) begin
      for (int t = 0; t < 16; t++) begin m_lv[k][p] = b[i]; p++; end
      ones += int'(b[i]);
    end
    if (c_par[k] != 0) begin
      pb = ((ones % 2) == 1);
      if (c_par[k] == 1) pb = ~pb;
      for (int t = 0; t < 16; t++) begin m_lv[k][p] = pb; p++; end
    end
    for (int t = 0; t < c_sb[k]; t++) begin m_lv[k][p] = 1'b1; p++; end
    m_tot[k] = p;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, exp);
    end
  endtask

  // s_tick generator, updated just after each rising edge
  initial begin
    s_tick = 1'b0;
    tph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (per == 0) s_tick = 1'($urandom_range(0, 1));
      else begin
        tph = (tph + 1) % per;
        s_tick = (tph == 0);
      end
    end
  end

  // Model advance on the same edges the DUT sees
  initial begin
    for (int k = 0; k < 4; k++) begin m_act[k] = 1'b0; m_n[k] = 0; m_tot[k] = 0; end
    forever begin
      @(posedge clk or posedge rst);
      for (int k = 0; k < 4; k++) begin
        if (rst) m_act[k] = 1'b0;
        else if (!m_act[k]) begin
          if (tx_start) begin build(k, din); m_n[k] = 0; m_act[k] = 1'b1; end
        end else if (s_tick) begin
          m_n[k]++;
          if (m_n[k] >= m_tot[k]) m_act[k] = 1'b0;
        end
      end
    end
  end

  // Cycle checker on the falling edge
  initial begin : cyc_chk
    logic [2:0] got, exp;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        exp[2] = m_act[k] ? m_lv[k][m_n[k]] : 1'b1;
        exp[1] = m_act[k];
        exp[0] = m_act[k] && s_tick && (m_n[k] == m_tot[k] - 1);
        got = {o_tx[k], o_busy[k], o_done[k]};
        checks++;
        if (got !== exp) begin
          errs++;
          $display("FAIL cycle inst%0d at %0t: tx/busy/done got %b want %b", k, $time, got, exp);
        end
      end
    end
  end

  task automatic pulse(input logic [7:0] b);
    din = b;
    tx_start = 1'b1;
    @(posedge clk); #2;
    tx_start = 1'b0;
    din = 8'($urandom);
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (o_busy != 4'h0 && n < lim) begin @(posedge clk); #2; n++; end
    chk("idle_timeout", 32'(o_busy), 32'h0);
  endtask

  // Samples the 8N1 line mid-bit; call right after the accepting edge, per=1
  task automatic rx_decode(output logic [7:0] b);
    int e;
    e = 0;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      while (e < 16 * (i + 1) + 8) begin @(posedge clk); #2; e++; end
      b[i] = o_tx[0];
    end
  endtask

  typedef struct {
    logic [7:0] din;
    int         per;
    logic [9:0] bits;   // [0]=start ... [9]=stop on the 8N1 line
    logic       pe;
    logic       po;
  } vec_t;

  vec_t tbl[5];
  int   perm[256];

  initial begin
    int e, cnt[4], exp_len, tmp, j, wd;
    logic [7:0] rb;

    rst = 1'b1; tx_start = 1'b0; din = '0; per = 1; errs = 0; checks = 0;
    tbl[0] = '{8'hA5, 1, 10'b1101001010, 1'b0, 1'b1};
    tbl[1] = '{8'h3C, 4, 10'b1001111000, 1'b0, 1'b1};
    tbl[2] = '{8'h07, 1, 10'b1000001110, 1'b1, 1'b0};
    tbl[3] = '{8'h00, 2, 10'b1000000000, 1'b0, 1'b1};
    tbl[4] = '{8'hFF, 1, 10'b1111111110, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #2;
    chk("reset_tx", 32'(o_tx), 32'hF);
    chk("reset_busy", 32'(o_busy), 32'h0);
    chk("reset_done", 32'(o_done), 32'h0);
    rst = 1'b0;
    @(posedge clk); #2;

    // Directed frames: mid-bit levels, parity bit, busy length
    for (int v = 0; v < 5; v++) begin
      per = tbl[v].per;
      repeat (per + 2) begin @(posedge clk); #2; end
      while (!s_tick) begin @(posedge clk); #2; end
      pulse(tbl[v].din);
      chk("busy_rise", 32'(o_busy), 32'hF);
      e = 0;
      for (int k = 0; k < 4; k++) cnt[k] = 1;
      while (o_busy != 4'h0 && e < 200 * per) begin
        @(posedge clk); #2; e++;
        for (int k = 0; k < 4; k++) if (o_busy[k]) cnt[k]++;
        for (int b = 0; b < 10; b++) begin
          if (e == (16 * b + 8) * per) begin
            chk("bit_level", 32'(o_tx[0]), 32'(tbl[v].bits[b]));
            if (b == 9) begin
              chk("even_parity", 32'(o_tx[1]), 32'(tbl[v].pe));
              chk("odd_parity", 32'(o_tx[2]), 32'(tbl[v].po));
            end
          end
        end
      end
      for (int k = 0; k < 4; k++) begin
        exp_len = ((9 + ((c_par[k] != 0) ? 1 : 0)) * 16 + c_sb[k]) * per;
        chk("busy_len", 32'(cnt[k]), 32'(exp_len));
      end
    end

    // Start while busy is ignored; start right after done begins a new frame
    per = 1;
    repeat (3) begin @(posedge clk); #2; end
    pulse(8'h55);
    repeat (40) begin @(posedge clk); #2; end
    pulse(8'hFF);
    chk("busy_hold", 32'(o_busy[0]), 32'h1);
    wd = 0;
    while (!o_done[0] && wd < 400) begin @(posedge clk); #2; wd++; end
    chk("done_seen", 32'(o_done[0]), 32'h1);
    @(posedge clk); #2;
    chk("idle_gap", 32'(o_busy[0]), 32'h0);
    pulse(8'h81);
    chk("b2b_busy", 32'(o_busy[0]), 32'h1);
    rx_decode(rb);
    chk("b2b_byte", 32'(rb), 32'h81);
    wait_idle(400);

    // Asynchronous reset in data bit 3, then a clean frame
    @(posedge clk); #2;
    pulse(8'h00);
    repeat (70) begin @(posedge clk); #2; end
    #1 rst = 1'b1;
    #1;
    chk("async_rst_tx", 32'(o_tx), 32'hF);
    chk("async_rst_busy", 32'(o_busy), 32'h0);
    chk("async_rst_done", 32'(o_done), 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    pulse(8'h12);
    rx_decode(rb);
    chk("post_rst_byte", 32'(rb), 32'h12);
    wait_idle(400);

    // Random ticks, random bytes, random stray starts
    per = 0;
    for (int r = 0; r < 20; r++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
      pulse(8'($urandom));
      repeat ($urandom_range(50, 400)) begin
        @(posedge clk); #2;
        tx_start = ($urandom_range(0, 30) == 0);
        din = 8'($urandom);
      end
      tx_start = 1'b0;
      wait_idle(3000);
    end

    // Loopback: every byte value in shuffled order, back-to-back frames
    per = 1;
    @(posedge clk); #2;
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      pulse(8'(perm[i]));
      rx_decode(rb);
      chk("loopback", 32'(rb), 32'(perm[i]));
      wait_idle(400);
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
